// File: rtl/ddr3_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : ddr3_ctrl_pkg                                                 |
// | Description: Shared DDR3 controller definitions: command encoding,         |
// |              scheduler state type, address-field width defaults and the    |
// |              wait-counter load helper.                                      |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package ddr3_ctrl_pkg;

  // Address-field width defaults shared with the refresh controller and PHY
  localparam int BANK_W_DEF = 3;
  localparam int ROW_W_DEF  = 14;
  localparam int COL_W_DEF  = 10;

  // DRAM command bus encoding
  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACT_WAIT = 3'd1,
    ST_RW_WAIT  = 3'd2,
    ST_PRE_WAIT = 3'd3,
    ST_REF_WAIT = 3'd4
  } sched_state_t;

  // Value loaded into a wait counter for a timing of t cycles; 0 behaves as 1
  function automatic logic [15:0] f_wait_load(input logic [15:0] t);
    return (t == 16'd0) ? 16'd0 : t - 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rr_arbiter                                                    |
// | Description: Round-robin arbiter. The pointer names the highest-priority   |
// |              requester and moves to the port after each accepted grant.    |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;

  // Scan requesters starting at the pointer; first active one wins
  always_comb begin
    o_any       = 1'b0;
    o_grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[(int'(r_ptr) + k) % N]) begin
        o_any       = 1'b1;
        o_grant_idx = IW'((int'(r_ptr) + k) % N);
      end
    end
  end

  // One-hot form of the winning index
  always_comb begin
    o_grant = '0;
    if (o_any) o_grant[o_grant_idx] = 1'b1;
  end

  // Pointer moves past the granted port only when the grant is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_any) begin
      r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr3_cmd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : ddr3_cmd_scheduler                                            |
// | Description: Closed-page DDR3 command scheduler. Arbitrates host ports and |
// |              refresh, issues ACT->RD/WR->PRE or REF with runtime timings.  |
// |              All command-bus outputs are registered.                       |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module ddr3_cmd_scheduler
  import ddr3_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int BANK_W = BANK_W_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int COL_W  = COL_W_DEF,
  parameter int ADDR_W = BANK_W + ROW_W + COL_W,
  parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     ref_req,
  output logic                     ref_ack,
  input  logic [7:0]               t_rcd,
  input  logic [7:0]               t_ras,
  input  logic [7:0]               t_rtp,
  input  logic [7:0]               t_wr,
  input  logic [7:0]               t_rp,
  input  logic [15:0]              t_rfc,
  output logic                     cmd_valid,
  output logic [2:0]               cmd,
  output logic [BANK_W-1:0]        cmd_bank,
  output logic [ROW_W-1:0]         cmd_row,
  output logic [COL_W-1:0]         cmd_col,
  output logic [IDW-1:0]           cmd_id
);

  sched_state_t r_state, w_next_state;
  logic [15:0]  r_cnt;
  logic [7:0]   r_ras;
  logic         r_write;
  logic [BANK_W-1:0] r_bank;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [IDW-1:0]    r_id;

  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_grant_idx;
  logic              w_arb_any;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [15:0]       w_ras_load;
  logic w_slot, w_ref_pending, w_issue_ref, w_issue_act, w_issue_rw, w_issue_pre;

  // Output registers
  logic              r_cmd_valid;
  logic [2:0]        r_cmd;
  logic [BANK_W-1:0] r_cmd_bank;
  logic [ROW_W-1:0]  r_cmd_row;
  logic [COL_W-1:0]  r_cmd_col;
  logic [IDW-1:0]    r_cmd_id;
  logic [NREQ-1:0]   r_req_ready;
  logic              r_ref_ack;

  logic [2:0]        w_cmd;
  logic [BANK_W-1:0] w_bank;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [IDW-1:0]    w_id;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .clk         (clk),
    .rst         (reset),
    .i_req       (req_valid),
    .i_advance   (w_issue_act),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_arb_any)
  );

  assign w_sel_addr = req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
  assign w_ras_load = f_wait_load({8'd0, t_ras});

  // A new command may start in IDLE, or in the cycle a PRE/REF wait expires,
  // so the next command lands exactly tRP / tRFC after the previous one.
  // ref_req is ignored while our own ack is still on the bus so a requester
  // that drops it on seeing ack cannot trigger a second REF.
  always_comb begin
    w_slot        = (r_state == ST_IDLE) ||
                    (((r_state == ST_PRE_WAIT) || (r_state == ST_REF_WAIT)) && (r_cnt == 16'd0));
    w_ref_pending = ref_req && !r_ref_ack;
    w_issue_ref   = w_slot && w_ref_pending;
    w_issue_act   = w_slot && !w_ref_pending && w_arb_any;
    w_issue_rw    = (r_state == ST_ACT_WAIT) && (r_cnt == 16'd0);
    w_issue_pre   = (r_state == ST_RW_WAIT) && (r_cnt == 16'd0) && (r_ras == 8'd0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (w_slot) begin
      w_next_state = ST_IDLE;
      if (w_issue_ref)      w_next_state = ST_REF_WAIT;
      else if (w_issue_act) w_next_state = ST_ACT_WAIT;
    end else if (w_issue_rw) begin
      w_next_state = ST_RW_WAIT;
    end else if (w_issue_pre) begin
      w_next_state = ST_PRE_WAIT;
    end
  end

  // Command decode: host commands carry the full latched address, REF carries zeros
  always_comb begin
    w_cmd  = CMD_NOP;
    w_bank = '0;
    w_row  = '0;
    w_col  = '0;
    w_id   = '0;
    if (w_issue_ref) begin
      w_cmd = CMD_REF;
    end else if (w_issue_act) begin
      w_cmd  = CMD_ACT;
      w_bank = w_sel_addr[ADDR_W-1 -: BANK_W];
      w_row  = w_sel_addr[COL_W +: ROW_W];
      w_col  = w_sel_addr[COL_W-1:0];
      w_id   = w_grant_idx;
    end else if (w_issue_rw || w_issue_pre) begin
      w_cmd  = w_issue_pre ? CMD_PRE : (r_write ? CMD_WR : CMD_RD);
      w_bank = r_bank;
      w_row  = r_row;
      w_col  = r_col;
      w_id   = r_id;
    end
  end

  // Wait/tRAS counters and the access fields latched at grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_ras   <= '0;
      r_write <= 1'b0;
      r_bank  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_id    <= '0;
    end else begin
      if (w_issue_ref)      r_cnt <= f_wait_load(t_rfc);
      else if (w_issue_act) r_cnt <= f_wait_load({8'd0, t_rcd});
      else if (w_issue_rw)  r_cnt <= f_wait_load({8'd0, (r_write ? t_wr : t_rtp)});
      else if (w_issue_pre) r_cnt <= f_wait_load({8'd0, t_rp});
      else if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;

      if (w_issue_act)         r_ras <= w_ras_load[7:0];
      else if (r_ras != 8'd0)  r_ras <= r_ras - 8'd1;

      if (w_issue_act) begin
        r_write <= req_write[w_grant_idx];
        r_bank  <= w_sel_addr[ADDR_W-1 -: BANK_W];
        r_row   <= w_sel_addr[COL_W +: ROW_W];
        r_col   <= w_sel_addr[COL_W-1:0];
        r_id    <= w_grant_idx;
      end
    end
  end

  // Registered command bus and handshake pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_cmd_bank  <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_cmd_id    <= '0;
      r_req_ready <= '0;
      r_ref_ack   <= 1'b0;
    end else begin
      r_cmd_valid <= (w_cmd != CMD_NOP);
      r_cmd       <= w_cmd;
      r_cmd_bank  <= w_bank;
      r_cmd_row   <= w_row;
      r_cmd_col   <= w_col;
      r_cmd_id    <= w_id;
      r_req_ready <= w_issue_act ? w_grant : '0;
      r_ref_ack   <= w_issue_ref;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd       = r_cmd;
  assign cmd_bank  = r_cmd_bank;
  assign cmd_row   = r_cmd_row;
  assign cmd_col   = r_cmd_col;
  assign cmd_id    = r_cmd_id;
  assign req_ready = r_req_ready;
  assign ref_ack   = r_ref_ack;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_ddr3_cmd_scheduler                                         |
// | Description: Scoreboard bench: stimulus queues expected commands with the  |
// |              hand-computed gap to the previous command; a negedge monitor  |
// |              pops and compares every command the scheduler issues.         |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_ddr3_cmd_scheduler;

  localparam int AW = 27;
  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;

  logic        clk, reset;
  logic [1:0]  req_valid, req_write, req_ready;
  logic [2*AW-1:0] req_addr;
  logic        ref_req, ref_ack;
  logic [7:0]  t_rcd, t_ras, t_rtp, t_wr, t_rp;
  logic [15:0] t_rfc;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [2:0]  cmd_bank;
  logic [13:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        cmd_id;

  ddr3_cmd_scheduler #(.NREQ(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_ready(req_ready), .ref_req(ref_req), .ref_ack(ref_ack),
    .t_rcd(t_rcd), .t_ras(t_ras), .t_rtp(t_rtp), .t_wr(t_wr), .t_rp(t_rp), .t_rfc(t_rfc),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .cmd_id(cmd_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] fields;  // {cmd, bank, row, col, id}
    int          gap;     // cycles since previous command, -1 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_cyc = 0;
  int rem[2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got timeout required completion (cycle %0d)", name, cyc);
    exp_q.delete();
  endtask

  task automatic push(input logic [2:0] c, input logic [2:0] b, input logic [13:0] r,
                      input logic [9:0] col, input logic id, input int gap);
    exp_t e;
    e.fields = {c, b, r, col, id};
    e.gap    = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_access(input logic id, input logic wr, input logic [2:0] b,
                             input logic [13:0] r, input logic [9:0] col,
                             input int g_act, input int g_rw, input int g_pre);
    push(ACT, b, r, col, id, g_act);
    push(wr ? WR : RD, b, r, col, id, g_rw);
    push(PRE, b, r, col, id, g_pre);
  endtask

  task automatic set_port(input int p, input logic wr, input logic [2:0] b,
                          input logic [13:0] r, input logic [9:0] col, input int n);
    req_addr[p*AW +: AW] = {b, r, col};
    req_write[p] = wr;
    req_valid[p] = 1'b1;
    rem[p] = n;
  endtask

  task automatic set_t(input int rcd, input int ras, input int rtp, input int wr_t,
                       input int rp, input int rfc);
    t_rcd = 8'(rcd); t_ras = 8'(ras); t_rtp = 8'(rtp); t_wr = 8'(wr_t); t_rp = 8'(rp);
    t_rfc = 16'(rfc);
  endtask

  // One host-side cycle: withdraw ref_req / req_valid once they have been accepted
  task automatic hs_step();
    @(posedge clk); #1;
    if (ref_ack) ref_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (req_ready[i] && rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run_until_done(input string name);
    int b = 0;
    while ((ref_req || req_valid != 2'b00 || exp_q.size() != 0) && b < 300) begin
      hs_step();
      b++;
    end
    if (b >= 300) fail_now(name);
    repeat (3) hs_step();
  endtask

  task automatic wait_ready(input int p, input string name);
    int b = 0;
    do begin hs_step(); b++; end while (!req_ready[p] && b < 300);
    if (!req_ready[p]) fail_now(name);
  endtask

  // Monitor: every issued command is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] w_rdy;
    cyc++;
    if (cmd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", {61'd0, cmd}, {61'd0, NOP});
      end else begin
        e = exp_q.pop_front();
        chk("cmd_fields", {33'd0, cmd, cmd_bank, cmd_row, cmd_col, cmd_id}, {33'd0, e.fields});
        if (e.gap >= 0) chk("cmd_gap", 64'(cyc - last_cyc), 64'(e.gap));
        w_rdy = (e.fields[30:28] == ACT) ? (2'b01 << e.fields[0]) : 2'b00;
        chk("handshake", {61'd0, req_ready, ref_ack},
            {61'd0, w_rdy, (e.fields[30:28] == REF)});
      end
      last_cyc = cyc;
    end else begin
      chk("idle_nop", {58'd0, cmd, req_ready, ref_ack}, 64'd0);
    end
  end

  initial begin
    reset = 1'b1; ref_req = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
    rem[0] = 0; rem[1] = 0;
    set_t(3, 8, 2, 2, 3, 20);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {24'd0, cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, cmd_id, req_ready, ref_ack}, 64'd0);
    reset = 1'b0;
    repeat (2) hs_step();

    // 1: single read on port0, then a port1 request shows next ACT after tRP
    push_access(1'b0, 1'b0, 3'd2, 14'h12, 10'h40, -1, 3, 5);
    push_access(1'b1, 1'b0, 3'd5, 14'h1ABC, 10'h3FF, 3, 3, 5);
    set_port(0, 1'b0, 3'd2, 14'h12, 10'h40, 1);
    wait_ready(0, "t1_grant");
    set_port(1, 1'b0, 3'd5, 14'h1ABC, 10'h3FF, 1);
    run_until_done("t1_done");

    // 2: both ports continuously valid -> 0,1,0,1
    set_t(2, 3, 1, 1, 2, 20);
    push_access(1'b0, 1'b0, 3'd1, 14'h0001, 10'h001, -1, 2, 1);
    push_access(1'b1, 1'b1, 3'd6, 14'h2345, 10'h155, 2, 2, 1);
    push_access(1'b0, 1'b0, 3'd1, 14'h0001, 10'h001, 2, 2, 1);
    push_access(1'b1, 1'b1, 3'd6, 14'h2345, 10'h155, 2, 2, 1);
    set_port(0, 1'b0, 3'd1, 14'h0001, 10'h001, 2);
    set_port(1, 1'b1, 3'd6, 14'h2345, 10'h155, 2);
    run_until_done("t2_done");

    // 3: refresh raised mid-access waits for PRE + tRP; next ACT tRFC after REF
    set_t(3, 8, 2, 2, 3, 20);
    push_access(1'b0, 1'b0, 3'd3, 14'h0777, 10'h020, -1, 3, 5);
    push(REF, 3'd0, 14'd0, 10'd0, 1'b0, 3);
    push_access(1'b1, 1'b0, 3'd4, 14'h0055, 10'h0AA, 20, 3, 5);
    set_port(0, 1'b0, 3'd3, 14'h0777, 10'h020, 1);
    wait_ready(0, "t3_grant");
    ref_req = 1'b1;
    set_port(1, 1'b0, 3'd4, 14'h0055, 10'h0AA, 1);
    run_until_done("t3_done");

    // 4: ref and both ports together: REF first, rr pointer still at port0
    set_t(3, 8, 2, 2, 3, 5);
    push(REF, 3'd0, 14'd0, 10'd0, 1'b0, -1);
    push_access(1'b0, 1'b0, 3'd0, 14'h0000, 10'h000, 5, 3, 5);
    push_access(1'b1, 1'b0, 3'd7, 14'h3FFF, 10'h3FF, 3, 3, 5);
    ref_req = 1'b1;
    set_port(0, 1'b0, 3'd0, 14'h0000, 10'h000, 1);
    set_port(1, 1'b0, 3'd7, 14'h3FFF, 10'h3FF, 1);
    run_until_done("t4_done");

    // 5a: write with tWR outlasting tRAS
    set_t(3, 8, 2, 6, 3, 5);
    push_access(1'b0, 1'b1, 3'd7, 14'h3FFF, 10'h3FF, -1, 3, 6);
    set_port(0, 1'b1, 3'd7, 14'h3FFF, 10'h3FF, 1);
    run_until_done("t5a_done");

    // 5b: all timings zero behave as one cycle (rr now favours port1)
    set_t(0, 0, 0, 0, 0, 0);
    push_access(1'b1, 1'b1, 3'd2, 14'h0100, 10'h010, -1, 1, 1);
    push_access(1'b0, 1'b0, 3'd3, 14'h0200, 10'h020, 1, 1, 1);
    set_port(1, 1'b1, 3'd2, 14'h0100, 10'h010, 1);
    set_port(0, 1'b0, 3'd3, 14'h0200, 10'h020, 1);
    run_until_done("t5b_done");

    // 5c: zero tRFC, REF then ACT in the next cycle
    push(REF, 3'd0, 14'd0, 10'd0, 1'b0, -1);
    push_access(1'b0, 1'b0, 3'd1, 14'h0300, 10'h030, 1, 1, 1);
    ref_req = 1'b1;
    set_port(0, 1'b0, 3'd1, 14'h0300, 10'h030, 1);
    run_until_done("t5c_done");

    // 6: reset during RW_WAIT abandons the access and restarts rr at port0
    set_t(3, 8, 2, 2, 3, 5);
    push(ACT, 3'd6, 14'h0ABC, 10'h011, 1'b0, -1);
    push(RD, 3'd6, 14'h0ABC, 10'h011, 1'b0, 3);
    set_port(0, 1'b0, 3'd6, 14'h0ABC, 10'h011, 1);
    begin
      int b = 0;
      do begin hs_step(); b++; end while (!(cmd_valid && cmd == RD) && b < 300);
      if (b >= 300) fail_now("t6_rd");
    end
    reset = 1'b1;
    set_port(0, 1'b0, 3'd1, 14'h0011, 10'h001, 1);
    set_port(1, 1'b1, 3'd5, 14'h0022, 10'h002, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_outputs", {24'd0, cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, cmd_id, req_ready, ref_ack}, 64'd0);
    chk("midreset_queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    push_access(1'b0, 1'b0, 3'd1, 14'h0011, 10'h001, -1, 3, 5);
    push_access(1'b1, 1'b1, 3'd5, 14'h0022, 10'h002, 3, 3, 5);
    run_until_done("t6_done");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
